// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl : BCD h/m/s timekeeper with RUN / SET_HOUR / SET_MIN setting FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module time_set_ctrl (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_fmt,
  output logic [7:0] Hour24,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic [1:0] set_state,
  output logic       blink,
  output logic       fmt12,
  output logic       pm,
  output logic       hour_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       fmt12_q, fmt12_d;
  logic       hour_pulse_q, hour_pulse_d;

  // {carry, next} for a 00..59 BCD field; any illegal code restarts at 00
  function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd5) r = 9'h000;
    else if (v == 8'h59)                 r = 9'h100;
    else if (v[3:0] == 4'd9)             r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                                 r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd2 || (v[7:4] == 4'd2 && v[3:0] > 4'd3))
      r = 8'h00;
    else if (v == 8'h23)     r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [8:0] sec_inc, min_inc;
  assign sec_inc = bcd_inc60(sec_q);
  assign min_inc = bcd_inc60(min_q);

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q      <= RUN;
      hour_q       <= 8'h00;
      min_q        <= 8'h00;
      sec_q        <= 8'h00;
      blink_q      <= 1'b0;
      fmt12_q      <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      blink_q      <= blink_d;
      fmt12_q      <= fmt12_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    blink_d      = blink_q;
    fmt12_d      = fmt12_q ^ key_fmt;
    hour_pulse_d = 1'b0;

    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        // Whole carry chain resolves in one edge
        if (tick_1hz) begin
          sec_d = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_d = min_inc[7:0];
            if (min_inc[8]) begin
              hour_d       = bcd_inc24(hour_q);
              hour_pulse_d = 1'b1;
            end
          end
        end
        if (key_mode) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (tick_1hz) blink_d = ~blink_q;
        if (key_mode)     state_d = SET_MIN;
        else if (key_inc) hour_d  = bcd_inc24(hour_q);
      end
      SET_MIN: begin
        if (key_mode) begin
          state_d = RUN;
          sec_d   = 8'h00;
          blink_d = 1'b0;
        end else begin
          if (tick_1hz) blink_d = ~blink_q;
          if (key_inc)  min_d   = min_inc[7:0];
        end
      end
      default: begin
        state_d = RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  assign Hour24     = hour_q;
  assign Minute     = min_q;
  assign Second     = sec_q;
  assign set_state  = state_q;
  assign blink      = blink_q;
  assign fmt12      = fmt12_q;
  assign hour_pulse = hour_pulse_q;
  assign pm         = (hour_q[7:4] > 4'd1) || (hour_q[7:4] == 4'd1 && hour_q[3:0] >= 4'd2);

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl : directed + randomized bench against a seconds-of-day model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       cr, tick_1hz, key_mode, key_inc, key_fmt;
  logic [7:0] Hour24, Minute, Second;
  logic [1:0] set_state;
  logic       blink, fmt12, pm, hour_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers, mode 0=run 1=set hour 2=set minute
  int m_h, m_m, m_s, m_mode;
  bit m_blink, m_fmt, m_hp;

  time_set_ctrl dut (
    .clk       (clk),
    .cr        (cr),
    .tick_1hz  (tick_1hz),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .key_fmt   (key_fmt),
    .Hour24    (Hour24),
    .Minute    (Minute),
    .Second    (Second),
    .set_state (set_state),
    .blink     (blink),
    .fmt12     (fmt12),
    .pm        (pm),
    .hour_pulse(hour_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit md, input bit inc, input bit f);
    int sod;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
      m_blink = 0; m_fmt = 0; m_hp = 0;
      return;
    end
    m_hp  = 0;
    m_fmt = m_fmt ^ f;
    case (m_mode)
      0: begin
        if (t) begin
          m_hp = (m_m == 59 && m_s == 59);
          sod  = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h  = sod / 3600;
          m_m  = (sod / 60) % 60;
          m_s  = sod % 60;
        end
        if (md) begin m_mode = 1; m_blink = 0; end
      end
      1: begin
        if (t) m_blink = ~m_blink;
        if (md) m_mode = 2;
        else if (inc) m_h = (m_h + 1) % 24;
      end
      default: begin
        if (md) begin
          m_mode = 0; m_s = 0; m_blink = 0;
        end else begin
          if (t) m_blink = ~m_blink;
          if (inc) m_m = (m_m + 1) % 60;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("Hour24",     32'(Hour24),     32'(to_bcd(m_h)));
    chk("Minute",     32'(Minute),     32'(to_bcd(m_m)));
    chk("Second",     32'(Second),     32'(to_bcd(m_s)));
    chk("set_state",  32'(set_state),  32'(m_mode));
    chk("blink",      32'(blink),      32'(m_blink));
    chk("fmt12",      32'(fmt12),      32'(m_fmt));
    chk("pm",         32'(pm),         32'(m_h >= 12));
    chk("hour_pulse", 32'(hour_pulse), 32'(m_hp));
  endtask

  // Apply one cycle of inputs, then compare one time unit after the edge
  task automatic cyc(input bit r, input bit t, input bit md, input bit inc, input bit f);
    cr = r; tick_1hz = t; key_mode = md; key_inc = inc; key_fmt = f;
    @(posedge clk);
    model_step(r, t, md, inc, f);
    #1;
    cr = 0; tick_1hz = 0; key_mode = 0; key_inc = 0; key_fmt = 0;
    check_all();
  endtask

  initial begin
    cr = 1; tick_1hz = 0; key_mode = 0; key_inc = 0; key_fmt = 0;
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_fmt = 0; m_hp = 0;

    // Reset held with random key activity
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_hour", 32'(Hour24), 32'h00);
    chk("reset_state", 32'(set_state), 32'h0);

    // Set 23:59 through the set path, run into the hour rollover
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 23; i++) cyc(0, i % 3 == 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("run_sec_cleared", 32'(Second), 32'h00);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 0);
    chk("pre_roll", 32'({Hour24, Minute, Second}), 32'h235959);
    cyc(0, 1, 0, 0, 0);
    chk("rollover", 32'({Hour24, Minute, Second}), 32'h000000);
    chk("chime", 32'(hour_pulse), 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("chime_one_clk", 32'(hour_pulse), 32'h0);

    // Tick + mode in RUN, then full hour wrap, minute wrap, mode+inc collision
    cyc(0, 1, 1, 0, 0);
    chk("tick_and_mode", 32'({Second, 6'b0, set_state}), 32'h0101);
    for (int i = 0; i < 24; i++) cyc(0, i % 2 == 0, 0, 1, 0);
    chk("hour_wrap", 32'(Hour24), 32'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("mode_beats_inc", 32'({Hour24, 6'b0, set_state}), 32'h0502);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("min_wrap", 32'({Hour24, Minute}), 32'h0500);
    cyc(0, 0, 1, 0, 0);

    // Format toggles
    cyc(0, 0, 0, 0, 1);
    chk("fmt_on", 32'(fmt12), 32'h1);
    cyc(0, 1, 0, 0, 1);
    chk("fmt_off", 32'(fmt12), 32'h0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/time_set_ctrl.md
# time_set_ctrl

Timekeeping and time-set controller for the digital clock. It holds the BCD seconds, minutes and hours counters. A three-state FSM sequences normal running and hour/minute adjustment from debounced key pulses. It drives the 24-hour BCD hour onto the 24-to-12 hour converter, together with a 12/24 format select and an AM/PM flag for the display path.

## Interface
- No parameters; all widths and moduli are fixed (BCD, 24 h / 60 min / 60 s).
- clk  in  1  system clock; every register updates on its rising edge.
- cr  in  1  synchronous, active-high reset (clear); sampled on clk rising edge.
- tick_1hz  in  1  one-clk-wide pulse, once per second.
- key_mode  in  1  one-clk-wide debounced pulse; advances the FSM.
- key_inc  in  1  one-clk-wide debounced pulse; increments the field being set.
- key_fmt  in  1  one-clk-wide debounced pulse; toggles 12/24 display format.
- Hour24  out  8  BCD hour 00..23 ({tens,units}); feeds the 24-to-12 converter.
- Minute  out  8  BCD minute 00..59.
- Second  out  8  BCD second 00..59.
- set_state  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN.
- blink  out  1  toggles on every tick_1hz while in a SET state; 0 in RUN.
- fmt12  out  1  1 = display uses the converted 12-hour value; 0 = 24-hour.
- pm  out  1  1 when Hour24 >= 12 BCD (0x12).
- hour_pulse  out  1  one-clk pulse on the 59:59 -> 00:00 rollover in RUN (chime).

## Operation
- Reset values (cr=1): Hour24=0x00, Minute=0x00, Second=0x00, set_state=RUN, blink=0, fmt12=0, pm=0, hour_pulse=0. Reset overrides all other inputs in the same cycle.
- RUN state, on tick_1hz:
  - Second increments in BCD: units 9 -> 0 with tens+1; 0x59 -> 0x00 with a carry to Minute.
  - Minute uses the same BCD rule; 0x59 -> 0x00 carries to Hour24 and asserts hour_pulse.
  - Hour24: units 9 -> 0 with tens+1; 0x23 -> 0x00.
  - key_inc is ignored in RUN.
- FSM transitions on key_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR, blink is cleared to 0.
  - On SET_MIN -> RUN, Second is cleared to 0x00.
- SET_HOUR:
  - key_inc increments Hour24 mod 24 in BCD (0x23 -> 0x00). Minute is not affected.
  - tick_1hz does not advance time; it only toggles blink.
- SET_MIN:
  - key_inc increments Minute mod 60 in BCD (0x59 -> 0x00), with no carry into Hour24.
  - tick_1hz only toggles blink.
- key_fmt toggles fmt12 in every state. fmt12 is independent of the FSM.
- pm is combinational from the registered Hour24 (tens>1, or tens==1 and units>=2).
- Simultaneous events:
  - key_mode + key_inc in one cycle: the state change wins and key_inc is dropped.
  - tick_1hz + key_mode in RUN: the tick is applied, and the state moves to SET_HOUR in the same edge.
  - key_fmt + any other input: both take effect.
- Illegal set_state 11: return to RUN on the next clk edge.
- Hour24/Minute/Second never hold non-BCD or out-of-range values. Any such value returns to 0x00 on the next increment.

## Timing
- All outputs except pm are registered. They change on the clk edge that samples the causing pulse, with a latency of 1 clk.
- pm follows Hour24 with zero added latency.
- hour_pulse is high for exactly the one clk that follows the rollover edge.
- A full carry chain (23:59:59 -> 00:00:00) completes in a single edge.
- cr asserted mid-set (any state) returns to RUN with all counters at 0 on the next edge.

## Test plan
- Reset: hold cr for 2 clks with random key pulses -> all outputs 0, set_state=00.
- Preload 23:59:58 via the set path, return to RUN, apply 2 ticks:
  - Second is cleared to 00 on return, so the observed sequence is 23:59:00 -> 23:59:01 -> 23:59:02.
  - Then preload 23:59 and let it run to 59 s; the next tick -> 00:00:00, hour_pulse=1 for 1 clk, pm goes 1 -> 0.
- SET_HOUR: 24 key_inc from 0x00 -> passes 0x09 -> 0x10 and 0x19 -> 0x20, then 0x23 -> 0x00. Minute is unchanged and ticks only toggle blink.
- SET_MIN at 0x59, key_inc -> Minute=0x00 with Hour24 unchanged. key_mode -> RUN and Second=0x00.
- Same cycle key_mode + key_inc in SET_HOUR at 0x05 -> state=SET_MIN, Hour24 stays 0x05.
- key_fmt twice -> fmt12 1 then 0. At Hour24=0x12, pm=1; at 0x11, pm=0.
